// File: rtl/logical_unit_arbiter.sv
// rtl/logical_unit_arbiter.sv - round-robin two-requester front end for one shared logical unit
// Operand and result stages form a two-deep pipeline with a back-pressurable response channel.
module logical_unit_arbiter #(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [size-1:0] req0_A,
   input  logic [size-1:0] req0_B,
   input  logic [1:0]      req0_Sel,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [size-1:0] req1_A,
   input  logic [size-1:0] req1_B,
   input  logic [1:0]      req1_Sel,
   output logic [size-1:0] lu_A,
   output logic [size-1:0] lu_B,
   output logic [1:0]      lu_Sel,
   input  logic [size-1:0] lu_S,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [size-1:0] rsp_S
);

   logic            op_valid_q, op_valid_d;
   logic            op_id_q, op_id_d;
   logic [size-1:0] op_a_q, op_a_d;
   logic [size-1:0] op_b_q, op_b_d;
   logic [1:0]      op_sel_q, op_sel_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_id_q, rsp_id_d;
   logic [size-1:0] rsp_s_q, rsp_s_d;
   logic            last_grant_q, last_grant_d;

   logic advance_rsp;
   logic accept;
   logic grant0;
   logic grant1;

   always_comb begin
      advance_rsp = !rsp_valid_q || rsp_ready;
      // accept is forced low while reset is asserted so no requester sees a handshake that gets dropped
      accept      = reset && (!op_valid_q || advance_rsp);
      grant0      = req0_valid && (!req1_valid || last_grant_q);
      grant1      = req1_valid && (!req0_valid || !last_grant_q);
      req0_ready  = accept && grant0;
      req1_ready  = accept && grant1;
   end

   always_comb begin
      op_valid_d   = op_valid_q;
      op_id_d      = op_id_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_sel_d     = op_sel_q;
      last_grant_d = last_grant_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_s_d      = rsp_s_q;

      if (req0_ready || req1_ready) begin
         op_valid_d   = 1'b1;
         op_id_d      = req1_ready;
         op_a_d       = req1_ready ? req1_A : req0_A;
         op_b_d       = req1_ready ? req1_B : req0_B;
         op_sel_d     = req1_ready ? req1_Sel : req0_Sel;
         last_grant_d = req1_ready;
      end else if (op_valid_q && advance_rsp) begin
         op_valid_d = 1'b0;
         op_a_d     = '0;
         op_b_d     = '0;
         op_sel_d   = 2'd3;
      end

      if (op_valid_q && advance_rsp) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = op_id_q;
         rsp_s_d     = lu_S;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         op_valid_q   <= 1'b0;
         op_id_q      <= 1'b0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_sel_q     <= 2'd3;
         last_grant_q <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_s_q      <= '0;
      end else begin
         op_valid_q   <= op_valid_d;
         op_id_q      <= op_id_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_sel_q     <= op_sel_d;
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_s_q      <= rsp_s_d;
      end
   end

   assign lu_A      = op_a_q;
   assign lu_B      = op_b_q;
   assign lu_Sel    = op_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_S     = rsp_s_q;

endmodule

// File: tb/tb_logical_unit_arbiter.sv
// tb/tb_logical_unit_arbiter.sv - scoreboard bench for logical_unit_arbiter
module tb_logical_unit_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_A, req0_B, req1_A, req1_B;
   logic [1:0]  req0_Sel, req1_Sel;
   logic [31:0] lu_A, lu_B, lu_S;
   logic [1:0]  lu_Sel;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_S;

   typedef struct {
      logic        id;
      logic [31:0] s;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] lu_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
      case (sel)
         2'd0:    return a ^ b;
         2'd1:    return a | b;
         2'd2:    return a & b;
         default: return 32'd0;
      endcase
   endfunction

   assign lu_S = lu_fn(lu_A, lu_B, lu_Sel);

   logical_unit_arbiter #(.size(32)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_A(req0_A), .req0_B(req0_B), .req0_Sel(req0_Sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_A(req1_A), .req1_B(req1_B), .req1_Sel(req1_Sel),
      .lu_A(lu_A), .lu_B(lu_B), .lu_Sel(lu_Sel), .lu_S(lu_S),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_S(rsp_S)
   );

   task automatic new_op0();
      req0_A   = $urandom;
      req0_B   = $urandom;
      req0_Sel = 2'($urandom_range(0, 3));
   endtask

   task automatic new_op1();
      req1_A   = $urandom;
      req1_B   = $urandom;
      req1_Sel = 2'($urandom_range(0, 3));
   endtask

   // Advance to the next falling edge and keep the scoreboard in step with the handshakes seen there.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (!reset) begin
         q.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL sb_unexpected: got id=%0d S=%h, required no response", rsp_id, rsp_S);
            end else begin
               e = q.pop_front();
               if (rsp_id !== e.id || rsp_S !== e.s) begin
                  n_bad++;
                  $display("FAIL sb_result: got id=%0d S=%h, required id=%0d S=%h", rsp_id, rsp_S, e.id, e.s);
               end
            end
         end
         if (req0_valid && req0_ready) q.push_back('{id: 1'b0, s: lu_fn(req0_A, req0_B, req0_Sel)});
         if (req1_valid && req1_ready) q.push_back('{id: 1'b1, s: lu_fn(req1_A, req1_B, req1_Sel)});
      end
   endtask

   task automatic drain(input int n);
      repeat (n) begin
         step();
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; rsp_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      new_op0(); new_op1();
      repeat (2) begin
         step();
         n_cmp++;
         if ({req1_ready, req0_ready, rsp_valid} !== 3'b000 || lu_Sel !== 2'd3) begin
            n_bad++;
            $display("FAIL reset_idle: got rdy1=%b rdy0=%b rsp_valid=%b lu_Sel=%0d, required 0 0 0 3",
                     req1_ready, req0_ready, rsp_valid, lu_Sel);
         end
         n_cmp++;
         if (rsp_S !== 32'd0 || rsp_id !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rsp: got id=%0d S=%h, required 0 0", rsp_id, rsp_S);
         end
         @(posedge clk); #1;
      end
      reset = 1'b1;
      step();
      n_cmp++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL reset_first_grant: got rdy1=%b rdy0=%b, required 0 1", req1_ready, req0_ready);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain(3);
   endtask

   task automatic test_single_latency();
      logic [1:0]  sel_t [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
      logic [31:0] exp_t4 [4] = '{32'hFF00_FF00, 32'hFFF0_FFF0, 32'h00F0_00F0, 32'h0000_0000};
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req0_A = 32'hF0F0_F0F0; req0_B = 32'h0FF0_0FF0; req0_Sel = sel_t[i];
         req0_valid = 1'b1;
         step();
         n_cmp++;
         if (req0_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL lat_ready sel=%0d: got %b, required 1", sel_t[i], req0_ready);
         end
         @(posedge clk); #1;
         req0_valid = 1'b0;
         step();
         n_cmp++;
         if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL lat_early sel=%0d: got rsp_valid=%b, required 0", sel_t[i], rsp_valid);
         end
         @(posedge clk); #1;
         step();
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_S !== exp_t4[i]) begin
            n_bad++;
            $display("FAIL lat_result sel=%0d: got v=%b id=%0d S=%h, required v=1 id=0 S=%h",
                     sel_t[i], rsp_valid, rsp_id, rsp_S, exp_t4[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_round_robin();
      int   acc = 0, nrsp = 0, first = -1, last = -1, cyc = 0;
      logic g0, g1;
      rsp_ready = 1'b1;
      new_op1(); req1_valid = 1'b1;
      step();
      @(posedge clk); #1;
      req1_valid = 1'b0;
      drain(3);
      new_op0(); new_op1();
      req0_valid = 1'b1; req1_valid = 1'b1;
      while (nrsp < 8 && cyc < 40) begin
         step();
         g0 = req0_ready; g1 = req1_ready;
         if (acc < 8) begin
            n_cmp++;
            if ({g1, g0} !== ((acc % 2 == 0) ? 2'b01 : 2'b10)) begin
               n_bad++;
               $display("FAIL rr_grant #%0d: got rdy1=%b rdy0=%b, required req%0d", acc, g1, g0, acc % 2);
            end
         end
         if (rsp_valid && rsp_ready) begin
            n_cmp++;
            if (rsp_id !== 1'((nrsp % 2))) begin
               n_bad++;
               $display("FAIL rr_rsp_id #%0d: got %0d, required %0d", nrsp, rsp_id, nrsp % 2);
            end
            if (first < 0) first = cyc;
            last = cyc;
            nrsp++;
         end
         @(posedge clk); #1;
         if (g0 && req0_valid) begin acc++; new_op0(); end
         if (g1 && req1_valid) begin acc++; new_op1(); end
         if (acc >= 8) begin req0_valid = 1'b0; req1_valid = 1'b0; end
         cyc++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      n_cmp++;
      if (nrsp != 8 || last - first != 7) begin
         n_bad++;
         $display("FAIL rr_bubbles: got %0d responses over %0d cycles, required 8 over 8", nrsp, last - first + 1);
      end
      drain(2);
   endtask

   task automatic test_back_pressure();
      int          acc = 0, cyc = 0;
      logic        g1;
      logic [31:0] first_s = 32'd0;
      rsp_ready = 1'b0;
      new_op1(); req1_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         g1 = req1_ready;
         if (c >= 2) begin
            n_cmp++;
            if ({req1_ready, req0_ready} !== 2'b00 || rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_S !== first_s) begin
               n_bad++;
               $display("FAIL bp_hold c=%0d: got rdy=%b%b v=%b id=%0d S=%h, required rdy=00 v=1 id=1 S=%h",
                        c, req1_ready, req0_ready, rsp_valid, rsp_id, rsp_S, first_s);
            end
         end
         @(posedge clk); #1;
         if (g1) begin
            if (acc == 0) first_s = lu_fn(req1_A, req1_B, req1_Sel);
            acc++;
            new_op1();
         end
      end
      n_cmp++;
      if (acc != 2) begin
         n_bad++;
         $display("FAIL bp_accepts: got %0d, required 2", acc);
      end
      rsp_ready = 1'b1;
      while (acc < 6 && cyc < 20) begin
         step();
         g1 = req1_ready;
         @(posedge clk); #1;
         if (g1) begin acc++; new_op1(); end
         cyc++;
      end
      req1_valid = 1'b0;
      drain(4);
      n_cmp++;
      if (acc != 6 || q.size() != 0) begin
         n_bad++;
         $display("FAIL bp_drain: got %0d accepts %0d pending, required 6 accepts 0 pending", acc, q.size());
      end
   endtask

   task automatic test_single_requester();
      int   acc = 0, cyc = 0;
      logic g0, g1;
      rsp_ready = 1'b1;
      new_op1(); req1_valid = 1'b1;
      while (acc < 4 && cyc < 20) begin
         step();
         g0 = req0_ready; g1 = req1_ready;
         n_cmp++;
         if ({g1, g0} !== 2'b10) begin
            n_bad++;
            $display("FAIL solo_grant #%0d: got rdy1=%b rdy0=%b, required 1 0", acc, g1, g0);
         end
         @(posedge clk); #1;
         if (g1) begin acc++; new_op1(); end
         cyc++;
      end
      new_op0(); req0_valid = 1'b1;
      step();
      n_cmp++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL join_grant: got rdy1=%b rdy0=%b, required 0 1", req1_ready, req0_ready);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      step();
      n_cmp++;
      if ({req1_ready, req0_ready} !== 2'b10) begin
         n_bad++;
         $display("FAIL join_next: got rdy1=%b rdy0=%b, required 1 0", req1_ready, req0_ready);
      end
      @(posedge clk); #1;
      req1_valid = 1'b0;
      drain(3);
   endtask

   task automatic test_reset_midflight();
      int   acc = 0, cyc = 0;
      logic g0;
      rsp_ready = 1'b0;
      new_op0(); req0_valid = 1'b1;
      while (acc < 2 && cyc < 10) begin
         step();
         g0 = req0_ready;
         @(posedge clk); #1;
         if (g0) begin acc++; new_op0(); end
         cyc++;
      end
      req0_valid = 1'b0;
      step();
      n_cmp++;
      if (rsp_valid !== 1'b1 || acc != 2) begin
         n_bad++;
         $display("FAIL mid_inflight: got v=%b accepts=%0d, required v=1 accepts=2", rsp_valid, acc);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      step();
      @(posedge clk); #1;
      reset = 1'b1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         n_cmp++;
         if (rsp_valid !== 1'b0 || rsp_S !== 32'd0) begin
            n_bad++;
            $display("FAIL mid_dropped c=%0d: got v=%b S=%h, required v=0 S=0", c, rsp_valid, rsp_S);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; rsp_ready = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_A = '0; req0_B = '0; req0_Sel = '0;
      req1_A = '0; req1_B = '0; req1_Sel = '0;
      test_reset();
      test_single_latency();
      test_round_robin();
      test_back_pressure();
      test_single_requester();
      test_reset_midflight();
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_leftover: got %0d pending, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/logical_unit_arbiter.md
# logical_unit_arbiter

Two-requester arbiter and sequencer for one shared `logical_unit` instance (XOR/OR/AND/zero, selected by a 2-bit `Sel`). It accepts operand requests from two clients over valid/ready handshakes and grants them round-robin. It registers the winning operands into the shared unit, then returns the registered result with a requester ID over a single back-pressurable response channel. It sits beside the execute stage so that the main ALU path and a secondary client (e.g. a CSR/bit-manipulation helper) can share one logic block.

## Interface
Parameters:
- `size`, 32, operand/result width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled only on the rising edge of `clk`.
- `req0_valid` / `req1_valid`  in  1  requester N has an operation.
- `req0_ready` / `req1_ready`  out  1  requester N accepted this cycle when valid&ready.
- `req0_A`, `req0_B` / `req1_A`, `req1_B`  in  size  operands.
- `req0_Sel` / `req1_Sel`  in  2  op: 0 XOR, 1 OR, 2 AND, 3 zero.
- `lu_A`, `lu_B`  out  size  to shared unit, driven from the operand register.
- `lu_Sel`  out  2  to shared unit, driven from the operand register.
- `lu_S`  in  size  combinational result from shared unit.
- `rsp_valid`  out  1  result register holds a result.
- `rsp_ready`  in  1  consumer takes the result when valid&ready.
- `rsp_id`  out  1  requester the result belongs to.
- `rsp_S`  out  size  result.

## Operation
- Two-stage pipeline: operand stage (`op_valid`, `op_id`, A/B/Sel registers) and result stage (`rsp_valid`, `rsp_id`, `rsp_S`).
- `advance_rsp = !rsp_valid || rsp_ready`.
- Result stage loads `lu_S` and `op_id` when `op_valid && advance_rsp`.
- `accept = !op_valid || advance_rsp`. The operand stage loads the granted request when `accept` and at least one valid is present. Otherwise it clears `op_valid` if its contents moved on.
- Grant is round-robin:
  - `last_grant` holds the ID of the last accepted request.
  - With both valid, grant the requester that is not `last_grant`. With one valid, grant that one.
  - `last_grant` updates only on an actual grant.
- `reqN_ready = accept && grantN`. This is combinational from the valids and state. Ready is never asserted to a non-granted requester, so at most one ready is high per cycle.
- Idle operand stage drives `lu_A = lu_B = 0` and `lu_Sel = 3`.
- `lu_Sel = 3` results pass through as 0. The block does not special-case them.
- Requester contract: once valid is high, A/B/Sel stay stable until accepted. The block does not check this.

## Timing
- Reset (`reset` low at a rising edge) sets:
  - `op_valid = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_S = 0`.
  - Operand registers to 0 with Sel = 3.
  - `last_grant = 1`, so req0 wins the first contention.
- `reqN_ready` goes low in the same cycle `reset` is low, because `accept` is forced low during reset.
- Reset mid-operation drops in-flight ops and results silently. Nothing is replayed.
- Latency: handshake on edge N, then `rsp_valid = 1` after edge N+1 when the response path is unblocked.
- Throughput: 1 op per cycle with `rsp_ready` held high.
- Back-pressure:
  - If `rsp_valid && !rsp_ready`, both stages hold and both readys are 0. At most 2 ops are in flight.
  - When `rsp_ready` rises, both stages advance on the same edge and a new request can be accepted that cycle.
- Result is held stable while `rsp_valid && !rsp_ready`.
- Simultaneous request and response on the same edge is legal and must not drop or duplicate a result.

## Test plan
- **Reset and idle:** assert `reset` low for 2 cycles while both requesters are valid.
  - During reset: both readys 0, `rsp_valid` 0, `lu_Sel` 3.
  - First cycle after release: `req0_ready` 1, `req1_ready` 0.
- **Single op latency:** req0 sends A=0xF0F0_F0F0, B=0x0FF0_0FF0, Sel=0 at edge N, with `rsp_ready` 1.
  - After edge N+1: `rsp_valid` 1, `rsp_id` 0, `rsp_S` 0xFF00_FF00.
  - Repeat with Sel=1, expecting 0xFFF0_FFF0.
  - Repeat with Sel=2, expecting 0x00F0_00F0.
  - Repeat with Sel=3, expecting 0.
- **Round-robin fairness:** both requesters valid continuously for 8 ops, `rsp_ready` 1.
  - `rsp_id` sequence is 0,1,0,1,0,1,0,1, back-to-back with no bubbles.
- **Back-pressure:** stream req1 ops, hold `rsp_ready` 0 for 5 cycles.
  - `rsp_S`/`rsp_id` stay frozen and both readys are 0 after 2 accepts.
  - On release, results drain in order with no loss or duplication.
- **Single requester:** only req1 valid for 4 ops, then req0 joins.
  - req1 is granted every cycle while alone.
  - The first contended cycle grants req0, since `last_grant` is 1.
- **Reset mid-flight:** 2 ops in flight with `rsp_ready` 0, then pull `reset` low for 1 cycle.
  - `rsp_valid` is 0 afterwards and neither result ever appears.
